// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: front-end advance/hold/discard control for jumps, load interlocks and halt (perf counters under `SEQ_PERF_CNT_EN)
module pipeline_sequencer #(
  parameter int LD_BUBBLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] ins,
  input  logic        ins_valid,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic        halt_req,
  input  logic        resume,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        bubble,
  output logic [2:0]  seq_state,
  output logic [7:0]  stall_cnt,
  output logic [7:0]  flush_cnt
);
  typedef enum logic [2:0] {RUN = 3'b000, LD_STALL = 3'b001, BR_WAIT = 3'b010, HALT = 3'b011} state_t;
  state_t state, nxt;
  logic [1:0] cnt, cnt_nxt;
  logic [4:0] op;
  logic is_jmp, is_cjmp, is_ld;
  logic unused_ins;
  assign op = ins[23:19];
  assign unused_ins = ^ins[18:0];
  assign is_jmp = ins_valid && op == 5'b11000;
  assign is_cjmp = ins_valid && op[4:2] == 3'b111;
  assign is_ld = ins_valid && op == 5'b10100;
  assign seq_state = state;
  // state and load-bubble counter; reset aborts any stall in progress
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= RUN;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
    end
  // next state and Mealy pipeline controls; reset forces a safe flush/bubble
  always_comb begin
    nxt = state;
    cnt_nxt = cnt;
    pc_en = 1'b0;
    pc_sel = 2'b00;
    ifid_en = 1'b0;
    ifid_flush = 1'b0;
    bubble = 1'b0;
    case (state)
      RUN:
        if (halt_req) begin
          bubble = 1'b1;
          nxt = HALT;
        end else if (is_jmp) begin
          pc_en = 1'b1;
          pc_sel = 2'b01;
          ifid_flush = 1'b1;
        end else if (is_cjmp) begin
          ifid_flush = 1'b1;
          nxt = BR_WAIT;
        end else begin
          pc_en = 1'b1;
          ifid_en = 1'b1;
          cnt_nxt = is_ld ? LD_BUBBLES[1:0] : cnt;
          nxt = is_ld ? LD_STALL : RUN;
        end
      LD_STALL: begin
        bubble = 1'b1;
        cnt_nxt = cnt - 2'd1;
        nxt = cnt <= 2'd1 ? RUN : LD_STALL;
      end
      BR_WAIT: begin
        ifid_en = 1'b1;
        bubble = 1'b1;
        pc_en = br_valid && br_taken;
        pc_sel = br_valid && br_taken ? 2'b10 : 2'b00;
        ifid_flush = br_valid && br_taken;
        nxt = br_valid ? RUN : BR_WAIT;
      end
      HALT: begin
        bubble = 1'b1;
        nxt = resume ? RUN : HALT;
      end
      default: begin
        bubble = 1'b1;
        nxt = RUN;
      end
    endcase
    if (!reset) begin
      pc_en = 1'b0;
      pc_sel = 2'b00;
      ifid_en = 1'b0;
      ifid_flush = 1'b1;
      bubble = 1'b1;
    end
  end
`ifdef SEQ_PERF_CNT_EN
  logic [7:0] s_cnt, f_cnt;
  // saturating bubble and flush counters
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s_cnt <= '0;
      f_cnt <= '0;
    end else begin
      if (bubble && s_cnt != 8'hff) s_cnt <= s_cnt + 8'd1;
      if (ifid_flush && f_cnt != 8'hff) f_cnt <= f_cnt + 8'd1;
    end
  assign stall_cnt = s_cnt;
  assign flush_cnt = f_cnt;
`else
  assign stall_cnt = 8'h00;
  assign flush_cnt = 8'h00;
`endif
endmodule
